instr_sequencer: RTL and testbench
==================================

Name: instr_sequencer

Overview:
- Top-level fetch/decode/dispatch controller for the microcontroller core.
- Fetches 16-bit instructions from instruction memory and latches them into the instruction register (IR).
- Starts the matching execution sub-FSM (ALU-reg, ALU-immediate, load/store, branch) with a one-cycle start pulse, waits for its done, then advances or loads the PC.
- Handles NOP, HALT, illegal opcodes and hung handshakes through a watchdog.

Parameters:
- PC_W, 8, width of program counter / instruction address.
- NUM_UNITS, 4, number of execution sub-FSMs; opcodes 0..NUM_UNITS-1 dispatch to unit[opcode].
- TIMEOUT, 255, watchdog limit in cycles for fetch-ack or unit-done; 0 disables the watchdog.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- run  in  1  level enable; 1 = keep executing, 0 = stop at next instruction boundary.
- imem_addr  out  PC_W  fetch address, equals PC.
- imem_req  out  1  fetch request.
- imem_ack  in  1  fetch complete; imem_data valid this cycle.
- imem_data  in  16  fetched instruction.
- instruction  out  16  IR contents, fanned out to all sub-FSMs.
- unit_start  out  NUM_UNITS  one-hot start pulse.
- unit_done  in  NUM_UNITS  per-unit done.
- pc_load  in  1  sampled with the selected unit_done; 1 = branch taken.
- pc_load_val  in  PC_W  branch target.
- busy  out  1  high in FETCH, DECODE, EXEC.
- halted  out  1  HALT executed.
- fault  out  1  fault latched.
- fault_code  out  2  01 illegal opcode, 10 exec timeout, 11 fetch timeout.
- retired  out  16  count of completed instructions; wraps.

Behaviour:
- Reset (rst=0, async): state=IDLE; PC, IR, retired, watchdog = 0; every output 0. Takes effect immediately, including mid-fetch or mid-exec; a unit_start pulse in progress drops at once.
- All outputs are registered.
- IDLE: if run=1, go to FETCH next cycle.
- FETCH:
  - imem_req=1 and imem_addr=PC, both held until imem_ack.
  - On imem_ack: IR<=imem_data, go to DECODE.
  - run=0 does not abort a fetch.
- DECODE (1 cycle). Opcode = IR[15:12].
  - Opcode < NUM_UNITS: go to EXEC; unit_start[opcode]=1 for exactly the first EXEC cycle.
  - 0xE NOP: PC<=PC+1, retired+1, then FETCH if run else IDLE.
  - 0xF HALT: go to HALT; PC unchanged; halted=1 until reset.
  - Any other opcode: go to FAULT with code 01.
- EXEC:
  - Wait for unit_done[opcode]; it is accepted in any EXEC cycle, including the start cycle.
  - unit_done from non-selected units is ignored.
  - On accept:
    - PC<=pc_load ? pc_load_val : PC+1.
    - retired<=retired+1.
    - Next state FETCH if run=1, else IDLE.
- PC arithmetic is modulo 2^PC_W: all-ones + 1 = 0.
- Watchdog:
  - Cleared on entry to FETCH and to EXEC; increments each cycle while waiting.
  - Reaching TIMEOUT moves to FAULT with code 11 (FETCH) or 10 (EXEC).
  - If ack/done arrives in the same cycle the limit is reached, ack/done wins.
- FAULT: fault=1 and fault_code held, busy=0, no requests, no starts. Exits only via reset.
- Total latency for a unit op: 1 fetch-ack cycle minimum + 1 DECODE + EXEC cycles. A NOP with immediate ack takes 2 cycles fetch-to-fetch.

Decomposition:
- Shared package seq_pkg:
  - State encoding: IDLE, FETCH, DECODE, EXEC, HALT, FAULT.
  - Opcode constants: OP_NOP=4'hE, OP_HALT=4'hF.
  - Fault code constants.
- One sub-module, seq_watchdog: clear/enable inputs, TIMEOUT parameter, expired output. Reused by both wait states.

Test Plan:
- Reset, run=1, memory acks after 2 cycles with 16'h1044 (unit1). Expect: imem_addr=0; unit_start=4'b0010 for one cycle; done after 3 cycles gives PC=1, retired=1, next fetch at address 1.
- Branch: unit3 done with pc_load=1, pc_load_val=8'h40 → next imem_addr=8'h40. Separately, PC=8'hFF with normal done → PC wraps to 0.
- NOP 16'hE000 then HALT 16'hF000. Expect: PC increments once, retired=1; halted=1, busy=0, PC stays put; no further imem_req until reset.
- Illegal opcode 16'h7000 → fault=1, fault_code=01, no unit_start.
- TIMEOUT=4, unit never responds → fault_code=10 exactly 4 cycles after EXEC entry. With done arriving on the 4th cycle instead → no fault.
- Drive run=0 during EXEC → instruction retires, state goes to IDLE, imem_req stays 0. Assert rst=0 mid-FETCH → imem_req and busy drop immediately, PC=0.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared types and constants for the instruction sequencer and its helpers.
package seq_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StExec,
        StHalt,
        StFault
    } state_e;

    localparam logic [3:0] OP_NOP  = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [1:0] FAULT_NONE     = 2'b00;
    localparam logic [1:0] FAULT_ILLEGAL  = 2'b01;
    localparam logic [1:0] FAULT_EXEC_TO  = 2'b10;
    localparam logic [1:0] FAULT_FETCH_TO = 2'b11;

    // States in which the sequencer waits on an external handshake.
    function automatic logic is_wait_state(input state_e s);
        return (s == StFetch) || (s == StExec);
    endfunction

endpackage

// File: rtl/seq_watchdog.sv
// Handshake watchdog: counts cycles spent waiting and flags the cycle in which
// the TIMEOUT-th waiting cycle is reached. TIMEOUT of 0 disables it.
module seq_watchdog #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable && (count_q != LAST)) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign expired = (TIMEOUT != 0) && enable && (count_q == LAST);

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/decode/dispatch controller: fetches 16-bit instructions, starts the
// matching execution unit, and advances or loads the PC when it completes.
module instr_sequencer
    import seq_pkg::*;
#(
    parameter int unsigned PC_W      = 8,
    parameter int unsigned NUM_UNITS = 4,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run,
    output logic [PC_W-1:0]      imem_addr,
    output logic                 imem_req,
    input  logic                 imem_ack,
    input  logic [15:0]          imem_data,
    output logic [15:0]          instruction,
    output logic [NUM_UNITS-1:0] unit_start,
    input  logic [NUM_UNITS-1:0] unit_done,
    input  logic                 pc_load,
    input  logic [PC_W-1:0]      pc_load_val,
    output logic                 busy,
    output logic                 halted,
    output logic                 fault,
    output logic [1:0]           fault_code,
    output logic [15:0]          retired
);

    state_e          state_q;
    logic [PC_W-1:0] pc_q;

    logic [3:0]           opcode;
    logic [NUM_UNITS-1:0] op_onehot;
    logic                 op_is_unit;
    logic                 done_sel;
    logic [PC_W-1:0]      pc_inc;
    logic                 wd_clear;
    logic                 wd_enable;
    logic                 wd_expired;

    assign opcode     = instruction[15:12];
    assign op_onehot  = NUM_UNITS'(1) << opcode;
    assign op_is_unit = 32'(opcode) < NUM_UNITS;
    assign done_sel   = |(unit_done & op_onehot);
    assign pc_inc     = pc_q + 1'b1;
    assign imem_addr  = pc_q;

    // Counter restarts whenever a wait state is left, so every entry to
    // FETCH or EXEC sees a fresh count even on back-to-back EXEC -> FETCH.
    assign wd_enable = is_wait_state(state_q);
    assign wd_clear  = !wd_enable
                     || ((state_q == StFetch) && imem_ack)
                     || ((state_q == StExec) && done_sel);

    seq_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .expired (wd_expired)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            pc_q        <= '0;
            instruction <= '0;
            retired     <= '0;
            imem_req    <= 1'b0;
            unit_start  <= '0;
            busy        <= 1'b0;
            halted      <= 1'b0;
            fault       <= 1'b0;
            fault_code  <= FAULT_NONE;
        end else begin
            unit_start <= '0;
            unique case (state_q)
                StIdle: begin
                    if (run) begin
                        state_q  <= StFetch;
                        imem_req <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                StFetch: begin
                    if (imem_ack) begin
                        instruction <= imem_data;
                        imem_req    <= 1'b0;
                        state_q     <= StDecode;
                    end else if (wd_expired) begin
                        imem_req   <= 1'b0;
                        busy       <= 1'b0;
                        fault      <= 1'b1;
                        fault_code <= FAULT_FETCH_TO;
                        state_q    <= StFault;
                    end
                end
                StDecode: begin
                    if (op_is_unit) begin
                        unit_start <= op_onehot;
                        state_q    <= StExec;
                    end else if (opcode == OP_NOP) begin
                        pc_q     <= pc_inc;
                        retired  <= retired + 16'd1;
                        state_q  <= run ? StFetch : StIdle;
                        imem_req <= run;
                        busy     <= run;
                    end else if (opcode == OP_HALT) begin
                        halted  <= 1'b1;
                        busy    <= 1'b0;
                        state_q <= StHalt;
                    end else begin
                        busy       <= 1'b0;
                        fault      <= 1'b1;
                        fault_code <= FAULT_ILLEGAL;
                        state_q    <= StFault;
                    end
                end
                StExec: begin
                    // Completion beats a watchdog expiry in the same cycle.
                    if (done_sel) begin
                        pc_q     <= pc_load ? pc_load_val : pc_inc;
                        retired  <= retired + 16'd1;
                        state_q  <= run ? StFetch : StIdle;
                        imem_req <= run;
                        busy     <= run;
                    end else if (wd_expired) begin
                        busy       <= 1'b0;
                        fault      <= 1'b1;
                        fault_code <= FAULT_EXEC_TO;
                        state_q    <= StFault;
                    end
                end
                StHalt, StFault: begin
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Randomized bench for instr_sequencer: the bench plays memory and execution
// units and tracks the expected PC and retire count with plain arithmetic.
module tb_instr_sequencer;

    localparam int unsigned PC_W      = 8;
    localparam int unsigned NUM_UNITS = 4;
    localparam int unsigned TIMEOUT   = 4;

    logic        clk         = 1'b0;
    logic        rst         = 1'b0;
    logic        run         = 1'b0;
    logic        imem_ack    = 1'b0;
    logic [15:0] imem_data   = 16'h0;
    logic [3:0]  unit_done   = 4'h0;
    logic        pc_load     = 1'b0;
    logic [7:0]  pc_load_val = 8'h0;

    logic [7:0]  imem_addr;
    logic        imem_req;
    logic [15:0] instruction;
    logic [3:0]  unit_start;
    logic        busy;
    logic        halted;
    logic        fault;
    logic [1:0]  fault_code;
    logic [15:0] retired;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0]  pc_m  = 8'h0;
    logic [15:0] ret_m = 16'h0;

    instr_sequencer #(
        .PC_W      (PC_W),
        .NUM_UNITS (NUM_UNITS),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .imem_addr   (imem_addr),
        .imem_req    (imem_req),
        .imem_ack    (imem_ack),
        .imem_data   (imem_data),
        .instruction (instruction),
        .unit_start  (unit_start),
        .unit_done   (unit_done),
        .pc_load     (pc_load),
        .pc_load_val (pc_load_val),
        .busy        (busy),
        .halted      (halted),
        .fault       (fault),
        .fault_code  (fault_code),
        .retired     (retired)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL global_timeout: observed still running, expected finished");
        $fatal(1, "simulation time limit");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        run       = 1'b0;
        imem_ack  = 1'b0;
        unit_done = 4'h0;
        pc_load   = 1'b0;
        tick();
        rst   = 1'b1;
        pc_m  = 8'h0;
        ret_m = 16'h0;
    endtask

    task automatic wait_req();
        int n;
        n = 0;
        while (imem_req !== 1'b1 && n < 8) begin
            tick();
            n++;
        end
        check("fetch_req_seen", 32'(imem_req), 32'd1);
    endtask

    // Serve one fetch, acking on fetch cycle fd+1, and land in DECODE.
    task automatic fetch(input logic [15:0] ins, input int fd);
        wait_req();
        check("fetch_addr", 32'(imem_addr), 32'(pc_m));
        check("fetch_busy", 32'(busy), 32'd1);
        for (int i = 0; i < fd; i++) begin
            imem_data = 16'($urandom);
            unit_done = 4'($urandom);
            tick();
            check("fetch_req_hold", 32'(imem_req), 32'd1);
            check("fetch_addr_hold", 32'(imem_addr), 32'(pc_m));
        end
        unit_done = 4'h0;
        imem_ack  = 1'b1;
        imem_data = ins;
        tick();
        imem_ack  = 1'b0;
        imem_data = 16'($urandom);
        check("ir", 32'(instruction), 32'(ins));
        check("decode_req", 32'(imem_req), 32'd0);
        check("decode_busy", 32'(busy), 32'd1);
    endtask

    // From DECODE: run the selected unit, completing on EXEC cycle ed+1.
    task automatic exec_unit(input logic [3:0] op, input int ed, input bit ld,
                             input logic [7:0] lv, input bit stop);
        logic [3:0] sel;
        sel = 4'b0001 << op;
        tick();
        check("unit_start", 32'(unit_start), 32'(sel));
        for (int k = 0; k <= ed; k++) begin
            if (k == ed) begin
                unit_done   = sel | (4'($urandom) & ~sel);
                pc_load     = ld;
                pc_load_val = lv;
                if (stop) run = 1'b0;
            end else begin
                unit_done   = 4'($urandom) & ~sel;
                pc_load     = 1'($urandom);
                pc_load_val = 8'($urandom);
            end
            tick();
            if (k < ed) begin
                check("start_single", 32'(unit_start), 32'd0);
                check("exec_busy", 32'(busy), 32'd1);
                check("exec_no_fault", 32'(fault), 32'd0);
            end
        end
        unit_done = 4'h0;
        pc_load   = 1'b0;
        pc_m      = ld ? lv : pc_m + 8'd1;
        ret_m     = ret_m + 16'd1;
    endtask

    task automatic check_boundary();
        check("retired", 32'(retired), 32'(ret_m));
        check("pc", 32'(imem_addr), 32'(pc_m));
        check("next_req", 32'(imem_req), 32'(run));
        check("next_busy", 32'(busy), 32'(run));
        check("no_fault", 32'(fault), 32'd0);
    endtask

    task automatic run_instr(input logic [15:0] ins, input int fd, input int ed, input bit ld,
                             input logic [7:0] lv, input bit stop);
        logic [3:0] op;
        op = ins[15:12];
        fetch(ins, fd);
        if (op < 4'd4) begin
            exec_unit(op, ed, ld, lv, stop);
        end else begin
            if (stop) run = 1'b0;
            tick();
            pc_m  = pc_m + 8'd1;
            ret_m = ret_m + 16'd1;
        end
        check_boundary();
    endtask

    initial begin
        logic [3:0] op;
        int         r;

        // Reset state
        do_reset();
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_addr", 32'(imem_addr), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_fault", 32'(fault), 32'd0);
        check("rst_code", 32'(fault_code), 32'd0);
        check("rst_retired", 32'(retired), 32'd0);
        check("rst_ir", 32'(instruction), 32'd0);
        check("rst_start", 32'(unit_start), 32'd0);

        // Unit 1 op, ack after 2 cycles, done on 3rd EXEC cycle
        run = 1'b1;
        run_instr(16'h1044, 2, 2, 1'b0, 8'h00, 1'b0);

        // Taken branch, then load FF and wrap with a normal completion
        run_instr(16'h3123, 0, 1, 1'b1, 8'h40, 1'b0);
        run_instr(16'h2000, 1, 0, 1'b1, 8'hFF, 1'b0);
        run_instr(16'h0005, 0, 0, 1'b0, 8'h00, 1'b0);
        check("pc_wrap", 32'(imem_addr), 32'd0);

        // Ack on 4th fetch cycle and done on 4th EXEC cycle still win
        run_instr(16'h2abc, 3, 3, 1'b0, 8'h00, 1'b0);

        // Random mix of unit ops and NOPs
        for (int n = 0; n < 40; n++) begin
            r  = int'($urandom_range(0, 4));
            op = (r == 4) ? 4'hE : 4'(r);
            run_instr({op, 12'($urandom)}, int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 3)), 1'($urandom), 8'($urandom), 1'b0);
        end

        // run dropped during EXEC: retire then idle
        run_instr(16'h1000, 1, 1, 1'b0, 8'h00, 1'b1);
        repeat (3) begin
            tick();
            check("idle_req", 32'(imem_req), 32'd0);
            check("idle_busy", 32'(busy), 32'd0);
        end
        run = 1'b1;

        // NOP then HALT
        run_instr(16'hE000, 0, 0, 1'b0, 8'h00, 1'b0);
        fetch(16'hF000, 1);
        tick();
        check("halt_halted", 32'(halted), 32'd1);
        check("halt_busy", 32'(busy), 32'd0);
        check("halt_pc", 32'(imem_addr), 32'(pc_m));
        check("halt_retired", 32'(retired), 32'(ret_m));
        repeat (4) begin
            tick();
            check("halt_no_req", 32'(imem_req), 32'd0);
            check("halt_held", 32'(halted), 32'd1);
        end

        // Illegal opcode 7
        do_reset();
        run = 1'b1;
        fetch(16'h7000, 0);
        tick();
        check("ill_fault", 32'(fault), 32'd1);
        check("ill_code", 32'(fault_code), 32'd1);
        check("ill_busy", 32'(busy), 32'd0);
        repeat (2) begin
            check("ill_no_start", 32'(unit_start), 32'd0);
            check("ill_no_req", 32'(imem_req), 32'd0);
            tick();
        end

        // Random illegal opcode in 4..13
        do_reset();
        run = 1'b1;
        op  = 4'(4 + $urandom_range(0, 9));
        fetch({op, 12'($urandom)}, int'($urandom_range(0, 3)));
        tick();
        check("ill_rand_code", 32'(fault_code), 32'd1);
        check("ill_rand_start", 32'(unit_start), 32'd0);

        // Execution timeout: fault exactly 4 cycles after EXEC entry
        do_reset();
        run = 1'b1;
        fetch(16'h1000, 0);
        tick();
        check("to_start", 32'(unit_start), 32'b0010);
        repeat (3) begin
            unit_done = 4'($urandom) & 4'b1101;
            tick();
            check("to_exec_wait", 32'(fault), 32'd0);
        end
        unit_done = 4'h0;
        tick();
        check("to_exec_fault", 32'(fault), 32'd1);
        check("to_exec_code", 32'(fault_code), 32'd2);
        check("to_exec_busy", 32'(busy), 32'd0);

        // Fetch timeout
        do_reset();
        run = 1'b1;
        wait_req();
        repeat (3) begin
            tick();
            check("to_fetch_wait", 32'(fault), 32'd0);
        end
        tick();
        check("to_fetch_fault", 32'(fault), 32'd1);
        check("to_fetch_code", 32'(fault_code), 32'd3);
        check("to_fetch_req", 32'(imem_req), 32'd0);

        // Asynchronous reset mid-fetch
        do_reset();
        run = 1'b1;
        run_instr(16'h0001, 0, 0, 1'b1, 8'h77, 1'b0);
        rst = 1'b0;
        #1;
        check("arst_req", 32'(imem_req), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_pc", 32'(imem_addr), 32'd0);
        check("arst_retired", 32'(retired), 32'd0);
        tick();
        rst   = 1'b1;
        pc_m  = 8'h0;
        ret_m = 16'h0;

        // Asynchronous reset during the start pulse
        fetch(16'h3000, 0);
        tick();
        check("arst_exec_start", 32'(unit_start), 32'b1000);
        rst = 1'b0;
        #1;
        check("arst_start_drop", 32'(unit_start), 32'd0);
        check("arst_exec_busy", 32'(busy), 32'd0);
        tick();
        rst = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
